// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the response side.
//
// Signals:
//   in_valid/in_ready       request handshake; funct3, op1, op2, in_tag qualified by in_valid
//   flush                   synchronous abort of the in-flight operation
//   out_valid/out_ready     response handshake; out_result, out_tag qualified by out_valid
//   busy                    unit is not idle
interface alu_muldiv_if #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 5
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           funct3;
    logic [XLEN-1:0]      op1;
    logic [XLEN-1:0]      op2;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_result;
    logic [TAG_WIDTH-1:0] out_tag;
    logic                 busy;

    // Requester side (EX stage / testbench).
    modport master (
        output in_valid, funct3, op1, op2, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );

    // Execution unit side.
    modport slave (
        input  in_valid, funct3, op1, op2, in_tag, flush, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide.
// Latency: XLEN+1 cycles from acceptance to out_valid; 1 cycle for divide-by-zero/overflow.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   alu_muldiv_if.slave request/response bundle
module alu_muldiv #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    alu_muldiv_if.slave  bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q;
    logic [2:0]           f3_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 neg_q;      // final result must be negated
    logic [CW-1:0]        cnt_q;
    logic [XLEN-1:0]      a_q;        // multiplicand magnitude, or divisor magnitude
    logic [2*XLEN-1:0]    acc_q;      // mul: {partial product, multiplier}; div: low half dividend/quotient
    logic [XLEN:0]        rem_q;      // div partial remainder
    logic                 out_valid_q;
    logic [XLEN-1:0]      out_result_q;
    logic [TAG_WIDTH-1:0] out_tag_q;

    // Acceptance-time decode: signedness, magnitudes, special cases.
    logic            op1_s, op2_s, s1, s2, neg_d, div0, ovf;
    logic [XLEN-1:0] mag1, mag2, spec_res;

    always_comb begin
        op1_s    = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
        op2_s    = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
        s1       = op1_s & bus.op1[XLEN-1];
        s2       = op2_s & bus.op2[XLEN-1];
        mag1     = s1 ? -bus.op1 : bus.op1;
        mag2     = s2 ? -bus.op2 : bus.op2;
        // Remainder follows the dividend sign; product/quotient follow the sign XOR.
        neg_d    = (bus.funct3[2] & bus.funct3[1]) ? s1 : (s1 ^ s2);
        div0     = bus.funct3[2] && (bus.op2 == '0);
        ovf      = bus.funct3[2] && !bus.funct3[0] && (bus.op1 == INT_MIN) && (bus.op2 == '1);
        spec_res = div0 ? (bus.funct3[1] ? bus.op1 : '1)
                        : (bus.funct3[1] ? '0 : bus.op1);
    end

    // One iteration of each algorithm.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_acc;
    logic [XLEN+1:0]   rem_sh, div_diff;
    logic              div_ge;
    logic [XLEN:0]     div_rem;
    logic [2*XLEN-1:0] div_acc;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_acc  = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = {rem_q, acc_q[XLEN-1]};
        div_diff = rem_sh - {2'b00, a_q};
        // rem_sh < 2*divisor, so the top bit of the difference is a valid borrow flag.
        div_ge   = ~div_diff[XLEN+1];
        div_rem  = div_ge ? div_diff[XLEN:0] : rem_sh[XLEN:0];
        div_acc  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge};
    end

    // Sign correction and result selection on the final CALC cycle.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd, fin_res;

    always_comb begin
        prod    = neg_q ? -acc_q : acc_q;
        quo     = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rmd     = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        fin_res = f3_q[2] ? (f3_q[1] ? rmd : quo)
                          : ((f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            f3_q         <= '0;
            tag_q        <= '0;
            neg_q        <= 1'b0;
            cnt_q        <= '0;
            a_q          <= '0;
            acc_q        <= '0;
            rem_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else if (bus.flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        f3_q  <= bus.funct3;
                        tag_q <= bus.in_tag;
                        neg_q <= neg_d;
                        cnt_q <= '0;
                        if (div0 || ovf) begin
                            out_result_q <= spec_res;
                            out_tag_q    <= bus.in_tag;
                            out_valid_q  <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            rem_q   <= '0;
                            a_q     <= bus.funct3[2] ? mag2 : mag1;
                            acc_q   <= {{XLEN{1'b0}}, (bus.funct3[2] ? mag1 : mag2)};
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (cnt_q == CW'(XLEN)) begin
                        out_result_q <= fin_res;
                        out_tag_q    <= tag_q;
                        out_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (f3_q[2]) begin
                            acc_q <= div_acc;
                            rem_q <= div_rem;
                        end else begin
                            acc_q <= mul_acc;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // in_ready is gated by rst so it reads 0 throughout reset and 1 in the first cycle after.
    assign bus.in_ready   = rst && (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_tag    = out_tag_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed RV32M vectors, special cases,
// back-pressure, flush/reset aborts and a randomised back-to-back stream.
// Expected results are queued at acceptance and compared when out_valid rises.
module tb_alu_muldiv;
    localparam int XLEN = 32;
    localparam int TW   = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_muldiv_if #(.XLEN(XLEN), .TAG_WIDTH(TW)) bus ();
    alu_muldiv #(.XLEN(XLEN), .TAG_WIDTH(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [31:0]   res;
        logic [TW-1:0] tag;
    } exp_t;

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model built from native 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        logic        ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p  = '0;
        r  = '0;
        case (f)
            3'd0: begin p = 64'(sa * sb); r = p[31:0];  end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (ov ? a : 32'(sa / sb));
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : (ov ? 32'd0 : 32'(sa % sb));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for in_ready, accept on the next edge.
    // Returns just after the acceptance edge.
    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [TW-1:0] tag, input logic [31:0] e);
        int n = 0;
        bus.funct3   = f;
        bus.op1      = a;
        bus.op2      = b;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (bus.in_ready) sb_q.push_back('{res: e, tag: tag});
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Edges elapsed after the acceptance edge until out_valid; also whether busy held.
    task automatic wait_out(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 200) begin
            busy_ok &= bus.busy;
            tick();
            lat++;
        end
        busy_ok &= bus.busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3 rst = 1'b0;
        #2;
        n_total++;
        if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b000) $display("FAIL reset_ctrl: got %b expected 000", {bus.out_valid, bus.busy, bus.in_ready});
        else n_pass++;
        n_total++;
        if ({bus.out_result, bus.out_tag} !== 37'd0) $display("FAIL reset_data: got %h/%h expected 0/0", bus.out_result, bus.out_tag);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
        else n_pass++;
        tick();
    endtask

    task automatic test_calc();
        vec_t v[9] = '{
            '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
            '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
            '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
            '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
            '{3'd5, 32'hFFFF_FFFE, 32'h0000_0003, 32'h5555_5554},
            '{3'd7, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002}
        };
        int   lat;
        bit   bz;
        exp_t ex;
        for (int i = 0; i < 9; i++) begin
            send(v[i].f, v[i].a, v[i].b, TW'(i + 5), v[i].e);
            wait_out(lat, bz);
            n_total++;
            if (lat !== 33) $display("FAIL calc_latency[%0d]: got %0d expected 33", i, lat);
            else n_pass++;
            n_total++;
            if (bz !== 1'b1) $display("FAIL calc_busy[%0d]: got %b expected 1", i, bz);
            else n_pass++;
            n_total++;
            if (!bus.out_valid || sb_q.size() == 0) begin
                $display("FAIL calc_result[%0d]: got no result expected %h", i, v[i].e);
                sb_q.delete();
            end else begin
                ex = sb_q.pop_front();
                if ({bus.out_result, bus.out_tag} !== ex)
                    $display("FAIL calc_result[%0d]: got %h/%0d expected %h/%0d", i, bus.out_result, bus.out_tag, ex.res, ex.tag);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_special();
        vec_t v[6] = '{
            '{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF},
            '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF},
            '{3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005},
            '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005},
            '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}
        };
        int   lat;
        bit   bz;
        exp_t ex;
        for (int i = 0; i < 6; i++) begin
            send(v[i].f, v[i].a, v[i].b, TW'(20 + i), v[i].e);
            wait_out(lat, bz);
            // Result must already be valid in the cycle right after the acceptance edge.
            n_total++;
            if (lat !== 0) $display("FAIL special_latency[%0d]: got %0d extra edges expected 0", i, lat);
            else n_pass++;
            n_total++;
            if (!bus.out_valid || sb_q.size() == 0) begin
                $display("FAIL special_result[%0d]: got no result expected %h", i, v[i].e);
                sb_q.delete();
            end else begin
                ex = sb_q.pop_front();
                if ({bus.out_result, bus.out_tag} !== ex)
                    $display("FAIL special_result[%0d]: got %h/%0d expected %h/%0d", i, bus.out_result, bus.out_tag, ex.res, ex.tag);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        bit   bz;
        exp_t ex;
        bus.out_ready = 1'b0;
        send(3'd0, 32'd7, 32'd6, 5'd9, 32'd42);
        wait_out(lat, bz);
        sb_q.delete();
        for (int i = 0; i < 10; i++) begin
            bus.funct3   = 3'd0;
            bus.op1      = 32'd3;
            bus.op2      = 32'd11;
            bus.in_tag   = 5'd3;
            bus.in_valid = 1'b1;
            tick();
            n_total++;
            if ({bus.out_valid, bus.in_ready, bus.out_result, bus.out_tag} !== {1'b1, 1'b0, 32'd42, 5'd9})
                $display("FAIL bp_hold[%0d]: got v=%b rdy=%b %h/%0d expected v=1 rdy=0 0000002a/9", i, bus.out_valid, bus.in_ready, bus.out_result, bus.out_tag);
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        tick();
        n_total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) $display("FAIL bp_release: got v=%b rdy=%b expected v=0 rdy=1", bus.out_valid, bus.in_ready);
        else n_pass++;
        sb_q.push_back('{res: 32'd33, tag: 5'd3});
        tick();
        bus.in_valid = 1'b0;
        n_total++;
        if (bus.busy !== 1'b1) $display("FAIL bp_next_accept: got busy=%b expected 1", bus.busy);
        else n_pass++;
        wait_out(lat, bz);
        n_total++;
        if (!bus.out_valid || sb_q.size() == 0) begin
            $display("FAIL bp_next_result: got no result expected 00000021");
            sb_q.delete();
        end else begin
            ex = sb_q.pop_front();
            if ({bus.out_result, bus.out_tag} !== ex)
                $display("FAIL bp_next_result: got %h/%0d expected %h/%0d", bus.out_result, bus.out_tag, ex.res, ex.tag);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_flush();
        int   lat;
        bit   bz;
        bit   seen = 1'b0;
        exp_t ex;
        send(3'd0, 32'd100, 32'd200, 5'd7, 32'd20000);
        for (int i = 0; i < 9; i++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        sb_q.delete();
        n_total++;
        if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b010)
            $display("FAIL flush_idle: got busy=%b rdy=%b v=%b expected 0 1 0", bus.busy, bus.in_ready, bus.out_valid);
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            seen |= bus.out_valid;
            tick();
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL flush_no_output: got out_valid=1 expected 0");
        else n_pass++;
        send(3'd4, 32'd100, 32'd7, 5'd8, 32'd14);
        wait_out(lat, bz);
        n_total++;
        if (!bus.out_valid || sb_q.size() == 0) begin
            $display("FAIL flush_next_result: got no result expected 0000000e");
            sb_q.delete();
        end else begin
            ex = sb_q.pop_front();
            if ({bus.out_result, bus.out_tag} !== ex)
                $display("FAIL flush_next_result: got %h/%0d expected %h/%0d", bus.out_result, bus.out_tag, ex.res, ex.tag);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_rst_mid();
        send(3'd5, 32'd1000, 32'd9, 5'd11, 32'd111);
        for (int i = 0; i < 5; i++) tick();
        #2 rst = 1'b0;
        #1;
        sb_q.delete();
        n_total++;
        if ({bus.out_valid, bus.busy, bus.in_ready, bus.out_result, bus.out_tag} !== 40'd0)
            $display("FAIL rst_mid: got v=%b busy=%b rdy=%b %h/%0d expected all 0", bus.out_valid, bus.busy, bus.in_ready, bus.out_result, bus.out_tag);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_flush_accept();
        bus.funct3   = 3'd0;
        bus.op1      = 32'd5;
        bus.op2      = 32'd5;
        bus.in_tag   = 5'd1;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        n_total++;
        if ({bus.busy, bus.out_valid, bus.in_ready} !== 3'b001)
            $display("FAIL flush_accept: got busy=%b v=%b rdy=%b expected 0 0 1", bus.busy, bus.out_valid, bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int          lat;
        bit          bz;
        exp_t        ex;
        logic [2:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (i == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            send(f, a, b, TW'(i), model(f, a, b));
            wait_out(lat, bz);
            n_total++;
            if (!bus.out_valid || sb_q.size() == 0) begin
                $display("FAIL b2b_result[%0d]: got no result for f=%0d a=%h b=%h", i, f, a, b);
                sb_q.delete();
            end else begin
                ex = sb_q.pop_front();
                if ({bus.out_result, bus.out_tag} !== ex)
                    $display("FAIL b2b_result[%0d]: f=%0d a=%h b=%h got %h/%0d expected %h/%0d", i, f, a, b, bus.out_result, bus.out_tag, ex.res, ex.tag);
                else n_pass++;
            end
            tick();
            n_total++;
            if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b expected 1", i, bus.in_ready);
            else n_pass++;
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.funct3    = 3'd0;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.in_tag    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_calc();
        test_special();
        test_backpressure();
        test_flush();
        test_rst_mid();
        test_flush_accept();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised iterative multiply/divide unit implementing the RV32M `funct3` operations, with the datapath width set by `XLEN`. It sits in EX beside the combinational ALU and is selected when the decoder flags an M-extension R-type instruction (`funct7 = 0000001`). It takes operands through a valid/ready handshake and computes over multiple cycles. It returns the result and destination tag through a second valid/ready handshake.

## Interface
Parameters
- `XLEN`, default 32: operand/result width; must be ≥ 4 and even.
- `TAG_WIDTH`, default 5: width of the pass-through destination tag.

Ports
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit can accept; high only in IDLE and while `rst` is high.
- `funct3`  in  3  000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- `op1`, `op2`  in  XLEN  rs1/rs2 operands.
- `in_tag`  in  TAG_WIDTH  rd index, returned unchanged.
- `flush`  in  1  synchronous abort of any in-flight operation.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_result`  out  XLEN  result.
- `out_tag`  out  TAG_WIDTH  tag of the result.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - Acceptance happens when `in_valid && in_ready && !flush`.
  - On acceptance, latch `funct3`, `in_tag`, operand magnitudes, and sign flags.
- Operand sign rules:
  - op1 is signed for mul/mulh/mulhsu/div/rem.
  - op2 is signed for mul/mulh/div/rem.
  - Unsigned operands are never negated.
- Division special cases are resolved at acceptance. The FSM goes straight to DONE with the result loaded:
  - Divide by zero: div/divu → all ones; rem/remu → op1.
  - Signed overflow (op1 = 1 followed by XLEN−1 zeros, op2 = all ones): div → op1; rem → 0.
- CALC, multiply:
  - Radix-2 shift-add over magnitudes.
  - One bit per cycle, XLEN cycles, into a 2·XLEN accumulator.
- CALC, divide:
  - Restoring division over magnitudes.
  - One quotient bit per cycle, XLEN cycles.
  - XLEN+1-bit partial remainder.
- A counter of width $clog2(XLEN)+1 counts the CALC cycles.
- On the last CALC cycle, apply sign correction in the transition to DONE:
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ (truncation toward zero).
  - Remainder takes the sign of op1.
- Result selection: mul → low XLEN bits of the product; mulh/mulhsu/mulhu → high XLEN bits; div/divu → quotient; rem/remu → remainder.
- DONE:
  - `out_valid` = 1.
  - `out_result` and `out_tag` are held stable until `out_ready`.
  - On handshake, go to IDLE.
- Flush:
  - From any state, the next state is IDLE and `out_valid` goes to 0.
  - The in-flight result is discarded.
  - `flush` takes priority over both acceptance and output handshake in the same cycle.

## Timing
- Reset while `rst` is low: state IDLE; `out_valid` = 0, `out_result` = 0, `out_tag` = 0, `busy` = 0, `in_ready` = 0, counter = 0.
- After `rst` rises: `in_ready` = 1 in the first cycle.
- Reset asserted mid-operation clears everything immediately (asynchronously).
- Normal latency: acceptance edge E0, CALC on edges E1..E_XLEN, DONE entered at E_XLEN+1.
  - `out_valid` rises XLEN+1 cycles after acceptance (33 for XLEN=32).
- Special-case latency: `out_valid` high in the cycle after acceptance (1 cycle).
- Exactly one operation is in flight at a time; no new acceptance in CALC or DONE.
- Output handshake occurs on an edge with `out_valid && out_ready`.
  - `in_ready` is 1 in the next cycle.
  - The earliest new acceptance is the edge after the output handshake.
- `out_result` and `out_tag` retain their last value in IDLE and CALC; only `out_valid` qualifies them.
- `out_ready` held low indefinitely: DONE persists, and outputs do not change.

## Test plan
- mul 7 × 0xFFFFFFFD (−3), `in_tag` 5, `out_ready` = 1 → 0xFFFFFFEB, tag 5, `out_valid` exactly 33 cycles after acceptance, `busy` high throughout.
- mulh 0x80000000 × 0x80000000 → 0x40000000; mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; mulhsu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF; mul 0x80000000 × 0xFFFFFFFF → 0x80000000.
- div 0xFFFFFFF9 / 2 → 0xFFFFFFFD; rem → 0xFFFFFFFF; divu 0xFFFFFFFE / 3 → 0x55555554; remu → 2.
- div 5 / 0 → 0xFFFFFFFF; divu 5 / 0 → 0xFFFFFFFF; rem 5 / 0 → 5; div 0x80000000 / 0xFFFFFFFF → 0x80000000; rem → 0.
  - Each has `out_valid` 1 cycle after acceptance.
- Back-pressure: hold `out_ready` low 10 cycles in DONE.
  - `out_valid`, `out_result`, and `out_tag` stay stable; `in_valid` with new operands is not accepted (`in_ready` = 0).
  - Raise `out_ready` → IDLE next cycle; new request accepted the following edge.
- Abort cases:
  - `flush` on the 10th CALC cycle → IDLE next cycle, no `out_valid`; next request computes correctly.
  - `rst` low mid-CALC → all outputs at reset values immediately.
  - `flush` and `in_valid` together in IDLE → not accepted.
